// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and small helpers used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  localparam int unsigned OS_RATE    = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned os_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / (baud * OS_RATE);
  endfunction

  // Two-out-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity (XOR reduction) of a byte.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is only
// accepted when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == {CW{1'b0}});
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy next state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampled UART receiver: synchronizer, re-phasable tick divider,
// frame FSM with 3-sample majority voting, error pulses and output FIFO.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RxD,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned OS_DIV = os_div(CLK_FREQ, BAUD);
  localparam int unsigned DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_W-1:0] div_q;
  uart_rx_state_t state_q;
  logic [3:0]     tick_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     data_q;
  logic           samp_lo_q, samp_mid_q;
  logic           par_bad_q;
  logic           frame_err_q, parity_err_q, overrun_q;

  logic           fall_s, tick_s, restart_s;
  logic [4:0]     tick_num_s, lo_pt_s, mid_pt_s, hi_pt_s;
  logic           vote_s, vote_now_s, bit_end_s, push_s;
  logic           full_s, empty_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_s    = rx_prev_q & ~rx_sync_q;
  assign restart_s = (state_q == IDLE) & fall_s;
  assign tick_s    = (div_q == DIV_LAST);

  // Free-running oversample divider, re-phased on a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= {DIV_W{1'b0}};
    end else if (restart_s || tick_s) begin
      div_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Sample points: the start bit is judged one tick early so its vote
  // completes at tick 8; all other bits vote on ticks 7/8/9.
  always_comb begin
    tick_num_s = {1'b0, tick_cnt_q} + 5'd1;
    if (state_q == START) begin
      lo_pt_s  = 5'(SAMPLE_LO - 1);
      mid_pt_s = 5'(SAMPLE_MID - 1);
      hi_pt_s  = 5'(SAMPLE_HI - 1);
    end else begin
      lo_pt_s  = 5'(SAMPLE_LO);
      mid_pt_s = 5'(SAMPLE_MID);
      hi_pt_s  = 5'(SAMPLE_HI);
    end
  end

  assign vote_s     = maj3(samp_lo_q, samp_mid_q, rx_sync_q);
  assign vote_now_s = tick_s & (tick_num_s == hi_pt_s);
  assign bit_end_s  = tick_s & (tick_num_s == 5'(OS_RATE));
  assign push_s     = (state_q == STOP) & vote_now_s & vote_s & ~par_bad_q;

  // Frame FSM: bit timing, voting, data shift and error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      data_q       <= 8'h00;
      samp_lo_q    <= 1'b1;
      samp_mid_q   <= 1'b1;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      if (tick_s) begin
        tick_cnt_q <= tick_cnt_q + 4'd1;
        if (tick_num_s == lo_pt_s)  samp_lo_q  <= rx_sync_q;
        if (tick_num_s == mid_pt_s) samp_mid_q <= rx_sync_q;
      end
      case (state_q)
        IDLE: begin
          if (fall_s) begin
            state_q    <= START;
            tick_cnt_q <= 4'd0;
            par_bad_q  <= 1'b0;
          end
        end
        START: begin
          if (vote_now_s && vote_s) begin
            state_q <= IDLE;
          end else if (bit_end_s) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        DATA: begin
          if (vote_now_s) begin
            data_q    <= {vote_s, data_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          if (bit_end_s && (bit_cnt_q == 3'd0)) begin
            state_q <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (vote_now_s) par_bad_q <= vote_s ^ parity8(data_q) ^ PARITY_ODD;
          if (bit_end_s)  state_q   <= STOP;
        end
        STOP: begin
          if (vote_now_s) begin
            if (!vote_s) begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end else begin
              parity_err_q <= par_bad_q;
              state_q      <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A good byte that finds the FIFO full with no pop is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_s & full_s & ~rx_ready;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_s),
    .push_data_i (data_q),
    .pop_i       (rx_ready),
    .head_o      (rx_data),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (fifo_count)
  );

  assign rx_valid   = ~empty_s;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
